// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the multicycle RISC-V controller:
// state enum, opcodes, mux/ALU encodings, control bundle.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_FUNCT  = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALUOUT  = 2'b00,
    RES_MEMDATA = 2'b01,
    RES_ALU     = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_t;

  typedef struct packed {
    logic        pc_update;
    logic        branch;
    logic        adr_src;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    logic        instr_done;
    logic        illegal;
    result_src_t result_src;
    src_a_t      alu_src_a;
    src_b_t      alu_src_b;
    alu_op_t     alu_op;
  } ctrl_t;

  // DECODE dispatch; anything unsupported traps.
  function automatic state_t decode_op(
    input logic [6:0] op
  );
    state_t s;
    s = S_TRAP;
    unique case (1'b1)
      (op == OP_LOAD),
      (op == OP_STORE):  s = S_MEMADR;
      (op == OP_RTYPE):  s = S_EXECR;
      (op == OP_ITYPE):  s = S_EXECI;
      (op == OP_BRANCH): s = S_BRANCH;
      (op == OP_JAL):    s = S_JAL;
      default:           s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle. master = controller,
// slave = datapath. mem_ready only with MULTICYCLE_MEM_WAIT_EN.
interface multicycle_controller_if;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
`ifdef MULTICYCLE_MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op,
    input  funct3,
    input  zero,
`ifdef MULTICYCLE_MEM_WAIT_EN
    input  mem_ready,
`endif
    output pc_write,
    output adr_src,
    output mem_write,
    output ir_write,
    output result_src,
    output alu_src_a,
    output alu_src_b,
    output alu_op,
    output reg_write,
    output instr_done,
    output illegal
  );

  modport slave (
    output op,
    output funct3,
    output zero,
`ifdef MULTICYCLE_MEM_WAIT_EN
    output mem_ready,
`endif
    input  pc_write,
    input  adr_src,
    input  mem_write,
    input  ir_write,
    input  result_src,
    input  alu_src_a,
    input  alu_src_b,
    input  alu_op,
    input  reg_write,
    input  instr_done,
    input  illegal
  );

endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// Pure state -> control decode (Moore part of the controller).
// in: state; out: ctrl bundle (ungated strobes).
module multicycle_ctrl_outdec
  import riscv_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.adr_src    = 1'b0;
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALU;
        ctrl.pc_update  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_MEMDATA;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALU_BRANCH;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
      end
      S_TRAP: begin
        ctrl.illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM. Ports: clk, rst_n, bus (master).
// MULTICYCLE_MEM_WAIT_EN adds the mem_ready wait handshake.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;
  logic   stall;
  logic   take_br;
  logic   unused_funct3;

  // Only funct3[0] (beq/bne) matters here.
  assign unused_funct3 = ^bus.funct3[2:1];

`ifdef MULTICYCLE_MEM_WAIT_EN
  // Memory-facing states stretch until mem_ready.
  assign stall = !bus.mem_ready &&
                 (state == S_FETCH   ||
                  state == S_MEMREAD ||
                  state == S_MEMWRITE);
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH:    state_next = S_DECODE;
      S_DECODE:   state_next = decode_op(bus.op);
      S_MEMADR:   state_next = bus.op[5] ? S_MEMWRITE
                                         : S_MEMREAD;
      S_MEMREAD:  state_next = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_next = S_ALUWB;
      S_MEMWB,
      S_MEMWRITE,
      S_ALUWB,
      S_BRANCH:   state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_FETCH;
    endcase
    if (stall) begin
      state_next = state;
    end
  end

  multicycle_ctrl_outdec u_outdec (
    .state (state),
    .ctrl  (ctrl)
  );

  // bne inverts the zero sense via funct3[0].
  assign take_br = ctrl.branch &
                   (bus.zero ^ bus.funct3[0]);

  always_comb begin
    bus.adr_src    = ctrl.adr_src;
    bus.result_src = ctrl.result_src;
    bus.alu_src_a  = ctrl.alu_src_a;
    bus.alu_src_b  = ctrl.alu_src_b;
    bus.alu_op     = ctrl.alu_op;
    bus.illegal    = ctrl.illegal;
    // Strobes: held off by a pending memory wait
    // and forced low while reset is asserted.
    bus.pc_write   = (ctrl.pc_update | take_br) &
                     !stall & rst_n;
    bus.ir_write   = ctrl.ir_write & !stall & rst_n;
    bus.mem_write  = ctrl.mem_write & !stall & rst_n;
    bus.instr_done = ctrl.instr_done & !stall & rst_n;
    bus.reg_write  = ctrl.reg_write & rst_n;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller.
// Scoreboard of expected per-cycle output vectors.
module tb_multicycle_controller;

  typedef enum {
    T_F, T_D, T_MA, T_MR, T_MWB, T_MW,
    T_ER, T_EI, T_AWB, T_BR, T_J, T_T
  } st_e;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic clk;
  logic rst_n;
  logic rdy;
  int   checks;
  int   errors;
  logic [14:0] exp_q[$];

  multicycle_controller_if bus();

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign bus.mem_ready = rdy;
`endif

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, adr_src, mem_write, ir_write, result_src,
  //  alu_src_a, alu_src_b, alu_op, reg_write, instr_done,
  //  illegal}
  function automatic logic [14:0] exp_out(
    input st_e        s,
    input logic       z,
    input logic [2:0] f3,
    input logic       rd,
    input logic       rn
  );
    logic pcw, adr, mw, irw, rw, dn, ill, stl;
    logic [1:0] rs, sa, sb, ao;
    {pcw, adr, mw, irw, rw, dn, ill} = '0;
    {rs, sa, sb, ao} = '0;
    case (s)
      T_F: begin
        irw = 1; sb = 2'b10; rs = 2'b10; pcw = 1;
      end
      T_D:   begin sa = 2'b01; sb = 2'b01; end
      T_MA:  begin sa = 2'b10; sb = 2'b01; end
      T_MR:  begin adr = 1; end
      T_MWB: begin rs = 2'b01; rw = 1; dn = 1; end
      T_MW:  begin adr = 1; mw = 1; dn = 1; end
      T_ER:  begin sa = 2'b10; ao = 2'b10; end
      T_EI:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      T_AWB: begin rw = 1; dn = 1; end
      T_BR: begin
        sa = 2'b10; ao = 2'b01; dn = 1;
        pcw = z ^ f3[0];
      end
      T_J: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      T_T: begin ill = 1; end
      default: ;
    endcase
    stl = !rd && (s == T_F || s == T_MR || s == T_MW);
    if (stl) begin
      irw = 0; pcw = 0; mw = 0; dn = 0;
    end
    if (!rn) begin
      pcw = 0; irw = 0; rw = 0; mw = 0; dn = 0;
    end
    return {pcw, adr, mw, irw, rs, sa, sb, ao, rw, dn, ill};
  endfunction

  function automatic logic [14:0] dut_out();
    return {bus.pc_write, bus.adr_src, bus.mem_write,
            bus.ir_write, bus.result_src, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.reg_write,
            bus.instr_done, bus.illegal};
  endfunction

  // Scoreboard push: expected vectors for one instruction.
  task automatic push_instr(
    input logic [6:0] op,
    input logic       z,
    input logic [2:0] f3
  );
    st_e s[$];
    case (op)
      LW: s = '{T_F, T_D, T_MA, T_MR, T_MWB};
      SW: s = '{T_F, T_D, T_MA, T_MW};
      RT: s = '{T_F, T_D, T_ER, T_AWB};
      IT: s = '{T_F, T_D, T_EI, T_AWB};
      BR: s = '{T_F, T_D, T_BR};
      JL: s = '{T_F, T_D, T_J, T_AWB};
      default: s = '{T_F, T_D, T_T};
    endcase
    foreach (s[i])
      exp_q.push_back(exp_out(s[i], z, f3, 1'b1, 1'b1));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] got, e;
    rst_n = 1'b0;
    rdy = 1'b1;
    bus.op = 7'b0;
    bus.funct3 = 3'b0;
    bus.zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(exp_out(T_F, 1'b0, 3'b0, 1'b1, 1'b0));
      @(negedge clk);
      got = dut_out();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset%0d: got %h expected %h",
                 i, got, e);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    logic [14:0] got, e;
    int n;
    bus.op = LW;
    push_instr(LW, bus.zero, bus.funct3);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      got = dut_out();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL lw c%0d: got %h expected %h",
                 c, got, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_branch();
    logic [14:0] got, e;
    logic [3:0] cases [3];
    cases = '{4'b1_000, 4'b1_001, 4'b0_001};
    foreach (cases[k]) begin
      bus.op = BR;
      bus.zero = cases[k][3];
      bus.funct3 = cases[k][2:0];
      push_instr(BR, bus.zero, bus.funct3);
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        got = dut_out();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL br%0d c%0d: got %h expected %h",
                   k, c, got, e);
        end
        next_cycle();
      end
    end
    bus.zero = 1'b0;
    bus.funct3 = 3'b0;
  endtask

  task automatic test_alu_jal();
    logic [14:0] got, e;
    logic [6:0] ops [3];
    int n;
    ops = '{RT, IT, JL};
    foreach (ops[k]) begin
      bus.op = ops[k];
      bus.zero = 1'($urandom);
      push_instr(ops[k], bus.zero, bus.funct3);
      n = exp_q.size();
      for (int c = 1; c <= n; c++) begin
        @(negedge clk);
        got = dut_out();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL op%h c%0d: got %h expected %h",
                   ops[k], c, got, e);
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_trap();
    logic [14:0] got, e;
    bus.op = BAD;
    push_instr(BAD, 1'b0, 3'b0);
    repeat (19)
      exp_q.push_back(exp_out(T_T, 1'b0, 3'b0, 1'b1, 1'b1));
    for (int c = 1; c <= 22; c++) begin
      bus.zero = 1'($urandom);
      bus.funct3 = 3'($urandom);
      @(negedge clk);
      got = dut_out();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL trap c%0d: got %h expected %h",
                 c, got, e);
      end
      next_cycle();
    end
    rst_n = 1'b0;
    #2;
    got = dut_out();
    e = exp_out(T_F, bus.zero, bus.funct3, 1'b1, 1'b0);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL trap_rst: got %h expected %h", got, e);
    end
    next_cycle();
    rst_n = 1'b1;
    bus.op = IT;
    push_instr(IT, bus.zero, bus.funct3);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      got = dut_out();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL post_trap c%0d: got %h expected %h",
                 c, got, e);
      end
      next_cycle();
    end
    bus.zero = 1'b0;
    bus.funct3 = 3'b0;
  endtask

  task automatic test_reset_mid();
    logic [14:0] got, e;
    bus.op = SW;
    push_instr(SW, 1'b0, 3'b0);
    for (int c = 1; c <= 4; c++) begin
      #1;
      got = dut_out();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL sw_pre c%0d: got %h expected %h",
                 c, got, e);
      end
      if (c < 4) next_cycle();
    end
    rst_n = 1'b0;
    #1;
    got = dut_out();
    e = exp_out(T_F, 1'b0, 3'b0, 1'b1, 1'b0);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL mid_rst: got %h expected %h", got, e);
    end
    next_cycle();
    rst_n = 1'b1;
    bus.op = RT;
    push_instr(RT, 1'b0, 3'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      got = dut_out();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL post_mid c%0d: got %h expected %h",
                 c, got, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] got, e;
    bus.op = SW;
    push_instr(SW, 1'b0, 3'b0);
    push_instr(RT, 1'b0, 3'b0);
    for (int c = 1; c <= 8; c++) begin
      if (c == 5) bus.op = RT;
      @(negedge clk);
      got = dut_out();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL b2b c%0d: got %h expected %h",
                 c, got, e);
      end
      checks++;
      if (bus.instr_done !== (c == 4 || c == 8)) begin
        errors++;
        $display("FAIL b2b_done c%0d: got %b expected %b",
                 c, bus.instr_done, (c == 4 || c == 8));
      end
      checks++;
      if (bus.mem_write !== (c == 4)) begin
        errors++;
        $display("FAIL b2b_mw c%0d: got %b expected %b",
                 c, bus.mem_write, (c == 4));
      end
      next_cycle();
    end
  endtask

`ifdef MULTICYCLE_MEM_WAIT_EN
  task automatic test_mem_wait();
    logic [14:0] got, e;
    st_e s[$];
    logic r[$];
    s = '{T_F, T_F, T_F, T_F, T_D, T_EI, T_AWB,
          T_F, T_D, T_MA, T_MW, T_MW, T_MW};
    r = '{0, 0, 0, 1, 1, 1, 1,
          1, 1, 1, 0, 0, 1};
    foreach (s[i])
      exp_q.push_back(exp_out(s[i], 1'b0, 3'b0, r[i], 1'b1));
    foreach (s[i]) begin
      bus.op = (i < 7) ? IT : SW;
      rdy = r[i];
      @(negedge clk);
      got = dut_out();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL wait c%0d: got %h expected %h",
                 i + 1, got, e);
      end
      next_cycle();
    end
    rdy = 1'b1;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rdy = 1'b1;
    test_reset();
    test_lw();
    test_branch();
    test_alu_jal();
    test_back_to_back();
    test_reset_mid();
    test_trap();
`ifdef MULTICYCLE_MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

endmodule
